rx_slot_scheduler: RTL and testbench

Packet-slot arbiter for the inband RX path. Sits between the per-channel RX FIFOs (data channels plus the command FIFO) and the packet builder. Grants one USB packet slot at a time to a ready requester in round-robin order, and gates the grant on USB FIFO space. For the granted requester it drives the shared read select and issues exactly one payload's worth of read strobes.

---
 rtl/rx_slot_scheduler.sv | 170 +++++++++++++++++
 tb/tb_rx_slot_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_slot_scheduler.sv
// Round-robin packet-slot arbiter for the inband RX path: grants one USB packet slot to a ready
// requester and streams exactly PAYLOAD_WORDS read/pad strobes. Optional macro RX_CMD_PRIORITY_EN.
module rx_slot_scheduler #(
    parameter int NUM_CHAN      = 2,
    parameter int PAYLOAD_WORDS = 252
) (
    input  logic              rxclk,
    input  logic              reset_n,
    input  logic [NUM_CHAN:0] chan_ready,
    input  logic [NUM_CHAN:0] chan_empty,
    input  logic              have_space,
    input  logic              hdr_done,
    output logic [3:0]        rd_select,
    output logic              chan_rdreq,
    output logic              pad,
    output logic              word_valid,
    output logic              slot_start,
    output logic              slot_done,
    output logic              busy
);

    localparam int NREQ  = NUM_CHAN + 1;
    localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_CHAN);
    localparam logic [8:0]       LAST_WORD = 9'(PAYLOAD_WORDS - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [8:0]       cnt_r;
    logic [8:0]       cnt_nxt_s;
    logic [SEL_W-1:0] rd_sel_r;
    logic [SEL_W-1:0] last_grant_r;
    logic [SEL_W-1:0] winner_s;
    logic             grant_s;
    logic             rr_upd_s;
    logic             chan_rdreq_r;
    logic             pad_r;
    logic             word_valid_r;
    logic             slot_start_r;
    logic             slot_done_r;
    logic             busy_r;

    // First ready requester after 'last', wrapping at NUM_CHAN; the search visits 'last' itself last.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_CHAN:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = last;
        found   = 1'b0;
        idx     = last;
        for (int i = 0; i < NREQ; i++) begin
            if (idx == LAST_IDX) begin
                idx = '0;
            end else begin
                idx = idx + SEL_W'(1);
            end
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    // Next-state, grant selection and word counter.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        grant_s     = 1'b0;
        rr_upd_s    = 1'b0;
        winner_s    = rd_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (have_space && (|chan_ready)) begin
                    grant_s     = 1'b1;
                    cnt_nxt_s   = 9'd0;
                    state_nxt_s = ST_HDR;
`ifdef RX_CMD_PRIORITY_EN
                    // A command win leaves last_grant alone so data-channel rotation is undisturbed.
                    if (chan_ready[NUM_CHAN]) begin
                        winner_s = LAST_IDX;
                        rr_upd_s = 1'b0;
                    end else begin
                        winner_s = rr_pick(chan_ready, last_grant_r);
                        rr_upd_s = 1'b1;
                    end
`else
                    winner_s = rr_pick(chan_ready, last_grant_r);
                    rr_upd_s = 1'b1;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hdr_done) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_READ: begin
                cnt_nxt_s = cnt_r + 9'd1;
                if (cnt_r == LAST_WORD) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and registered outputs derived from the upcoming state.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 9'd0;
            rd_sel_r     <= '0;
            last_grant_r <= LAST_IDX;
            chan_rdreq_r <= 1'b0;
            pad_r        <= 1'b0;
            word_valid_r <= 1'b0;
            slot_start_r <= 1'b0;
            slot_done_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (grant_s) begin
                rd_sel_r <= winner_s;
            end else begin
                rd_sel_r <= rd_sel_r;
            end
            if (rr_upd_s) begin
                last_grant_r <= winner_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
            // chan_empty sampled here governs the word produced in the following cycle.
            word_valid_r <= (state_nxt_s == ST_READ);
            chan_rdreq_r <= (state_nxt_s == ST_READ) && !chan_empty[rd_sel_r];
            pad_r        <= (state_nxt_s == ST_READ) && chan_empty[rd_sel_r];
            slot_start_r <= grant_s;
            slot_done_r  <= (state_nxt_s == ST_DONE);
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    assign rd_select  = 4'(rd_sel_r);
    assign chan_rdreq = chan_rdreq_r;
    assign pad        = pad_r;
    assign word_valid = word_valid_r;
    assign slot_start = slot_start_r;
    assign slot_done  = slot_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_rx_slot_scheduler.sv
// Randomized self-checking bench for rx_slot_scheduler against a slot-level reference model.
module tb_rx_slot_scheduler;

    localparam int NC = 2;
    localparam int PW = 252;

    logic        rxclk;
    logic        reset_n;
    logic [NC:0] chan_ready;
    logic [NC:0] chan_empty;
    logic        have_space;
    logic        hdr_done;
    logic [3:0]  rd_select;
    logic        chan_rdreq;
    logic        pad;
    logic        word_valid;
    logic        slot_start;
    logic        slot_done;
    logic        busy;

    int vectors;
    int miscompares;
    int model_last;

    rx_slot_scheduler #(.NUM_CHAN(NC), .PAYLOAD_WORDS(PW)) dut (
        .rxclk(rxclk), .reset_n(reset_n), .chan_ready(chan_ready), .chan_empty(chan_empty),
        .have_space(have_space), .hdr_done(hdr_done), .rd_select(rd_select),
        .chan_rdreq(chan_rdreq), .pad(pad), .word_valid(word_valid), .slot_start(slot_start),
        .slot_done(slot_done), .busy(busy)
    );

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    // One full slot: optional no-space phase, grant, header wait, payload, done.
    // empty_at: reads after which the granted FIFO goes empty (-1 never); abort_at: word at which reset hits (-1 never).
    task automatic run_slot(input logic [NC:0] rdy, input int space_delay, input int hdr_delay,
                            input int empty_at, input int abort_at);
        int  win;
        int  words;
        int  reads;
        int  pads;
        bit  seen;
        bit  exp_e;
        win = -1;
`ifdef RX_CMD_PRIORITY_EN
        if (rdy[NC]) win = NC;
`endif
        if (win < 0) begin
            for (int k = 1; k <= NC + 1; k++) begin
                if (win < 0 && rdy[(model_last + k) % (NC + 1)]) win = (model_last + k) % (NC + 1);
            end
            model_last = win;
        end
        chan_ready = rdy;
        chan_empty = '0;
        hdr_done   = 1'b1;
        seen       = 1'b0;
        if (space_delay > 0) begin
            have_space = 1'b0;
            for (int i = 0; i < space_delay; i++) begin
                @(negedge rxclk);
                vectors++;
                if (busy !== 1'b0 || slot_start !== 1'b0) begin
                    miscompares++;
                    $display("FAIL no_space: busy=%b slot_start=%b, required 0 0", busy, slot_start);
                end
            end
            have_space = 1'b1;
            @(negedge rxclk);
            seen = (slot_start === 1'b1);
        end else begin
            have_space = 1'b1;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge rxclk);
                seen = (slot_start === 1'b1);
            end
        end
        vectors++;
        if (!seen || rd_select !== 4'(win) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL grant: slot_start=%b rd_select=%0d busy=%b, required 1 %0d 1",
                     slot_start, rd_select, busy, win);
        end
        chan_ready = '0;
        hdr_done   = 1'b0;
        if (!seen) return;
        for (int d = 0; d < hdr_delay; d++) begin
            @(negedge rxclk);
            vectors++;
            if (word_valid !== 1'b0 || slot_start !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hdr_wait: word_valid=%b slot_start=%b busy=%b, required 0 0 1",
                         word_valid, slot_start, busy);
            end
        end
        hdr_done = 1'b1;
        @(negedge rxclk);
        hdr_done = 1'b0;
        words = 0; reads = 0; pads = 0; seen = 1'b0;
        for (int c = 0; c < PW + 8 && !seen; c++) begin
            if (abort_at >= 0 && words == abort_at) begin
                reset_n = 1'b0;
                #1;
                model_last = NC;
                vectors++;
                if ({rd_select, chan_rdreq, pad, word_valid, slot_start, slot_done, busy} !== 10'd0) begin
                    miscompares++;
                    $display("FAIL async_reset: outputs=%b, required all 0",
                             {rd_select, chan_rdreq, pad, word_valid, slot_start, slot_done, busy});
                end
                for (int i = 0; i < 3; i++) begin
                    @(negedge rxclk);
                    vectors++;
                    if (slot_done !== 1'b0 || busy !== 1'b0) begin
                        miscompares++;
                        $display("FAIL reset_hold: slot_done=%b busy=%b, required 0 0", slot_done, busy);
                    end
                end
                reset_n = 1'b1;
                return;
            end
            if (slot_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                exp_e = chan_empty[win];
                vectors++;
                if (word_valid !== 1'b1 || chan_rdreq !== !exp_e || pad !== exp_e || rd_select !== 4'(win)) begin
                    miscompares++;
                    $display("FAIL word %0d: valid=%b rdreq=%b pad=%b sel=%0d, required 1 %b %b %0d",
                             words + 1, word_valid, chan_rdreq, pad, rd_select, !exp_e, exp_e, win);
                end
                words++;
                if (exp_e) pads++; else reads++;
                if (empty_at >= 0 && reads == empty_at) chan_empty[win] = 1'b1;
                @(negedge rxclk);
            end
        end
        vectors++;
        if (!seen || words != PW || reads != ((empty_at < 0) ? PW : empty_at) ||
            word_valid !== 1'b0 || rd_select !== 4'(win) || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL slot_end: done=%b words=%0d reads=%0d pads=%0d sel=%0d, required 1 %0d %0d sel %0d",
                     seen, words, reads, pads, rd_select, PW, (empty_at < 0) ? PW : empty_at, win);
        end
        chan_empty = '0;
        @(negedge rxclk);
        vectors++;
        if (slot_done !== 1'b0 || busy !== 1'b0 || word_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done: slot_done=%b busy=%b word_valid=%b, required 0 0 0",
                     slot_done, busy, word_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; chan_ready = '0; chan_empty = '0; have_space = 1'b0; hdr_done = 1'b0;
        model_last = NC;
        repeat (2) @(negedge rxclk);
        vectors++;
        if ({rd_select, chan_rdreq, pad, word_valid, slot_start, slot_done, busy} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset: outputs=%b, required all 0",
                     {rd_select, chan_rdreq, pad, word_valid, slot_start, slot_done, busy});
        end
        reset_n = 1'b1;
        @(negedge rxclk);
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 6; i++) run_slot(3'b111, 0, 1, -1, -1);
    endtask

    task automatic test_basic();
        run_slot(3'b011, 0, 2, -1, -1);
        run_slot(3'b011, 0, 2, -1, -1);
        run_slot(3'b011, 0, 1, -1, -1);
    endtask

    task automatic test_no_space();
        run_slot(3'b001, 5, 2, -1, -1);
    endtask

    task automatic test_pad();
        run_slot(3'b001, 0, 2, 100, -1);
        run_slot(3'b100, 0, 1, 1, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_slot(3'($urandom_range(1, 7)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                     int'($urandom_range(1, 4)),
                     ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(1, PW - 1)), -1);
        end
    endtask

    task automatic test_reset_mid();
        run_slot(3'b010, 0, 2, -1, 50);
        @(negedge rxclk);
        run_slot(3'b011, 0, 2, -1, -1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_basic();
        test_no_space();
        test_pad();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
